// File: rtl/iobuf_pkg.sv
// iobuf_pkg: shared types and limits for the I/O pad bank controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: direction FSM state encoding, parameter range limits, counter width helper.
package iobuf_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,   // high-Z, waiting for the bus and synchroniser to settle
        ST_HIZ    = 2'd1,   // high-Z, input data valid
        ST_T2D    = 2'd2,   // high-Z turnaround before driving
        ST_DRIVE  = 2'd3    // pads driven from the output register
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;
    localparam int TURN_MIN  = 1;
    localparam int SYNC_MIN  = 2;
    localparam int SYNC_MAX  = 4;

    // The longest count ever loaded is the post-drive settle time.
    function automatic int cnt_width(input int turn_cycles, input int sync_stages);
        return $clog2(turn_cycles + sync_stages + 1);
    endfunction

endpackage

// File: rtl/iobuf_bank_ctl_if.sv
// iobuf_bank_ctl_if: host-side port of the pad bank (direction request, write data, read data, error flag).
// Latency: n/a (wiring only).
// Backpressure: none; drive_req is a level request acknowledged by drive_ack.
// Modports: master = host (PicoBlaze port side), slave = pad bank.
interface iobuf_bank_ctl_if #(
    parameter int WIDTH = 8
);
    logic             drive_req;
    logic             drive_ack;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             err_clr;
    logic             err_contention;

    modport master (
        output drive_req, wr_en, wr_data, err_clr,
        input  drive_ack, rd_data, rd_valid, err_contention
    );

    modport slave (
        input  drive_req, wr_en, wr_data, err_clr,
        output drive_ack, rd_data, rd_valid, err_contention
    );
endinterface

// File: rtl/iobuf_pad_bit.sv
// iobuf_pad_bit: one bidirectional pad with registered output data and registered tri-state control.
// Latency: one clock from ld/d or oe_n_d to the pin; reset floats the pin asynchronously.
// Backpressure: none. Ports: clk, reset, oe_n_d (next enable, 1 = high-Z), ld/d (data load), q (data flop), pad (pin).
module iobuf_pad_bit (
    input  logic clk,
    input  logic reset,
    input  logic oe_n_d,
    input  logic ld,
    input  logic d,
    output logic q,
    inout  wire  pad
);

    logic oe_n_q;

    // Both flops sit directly on the pin so they can be packed into the I/O cell.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oe_n_q <= 1'b1;
            q      <= 1'b0;
        end else begin
            oe_n_q <= oe_n_d;
            if (ld) begin
                q <= d;
            end
        end
    end

    assign pad = oe_n_q ? 1'bz : q;

endmodule

// File: rtl/iobuf_bank_ctl.sv
// iobuf_bank_ctl: bank of WIDTH bidirectional pads with a turnaround-enforcing direction FSM and input synchroniser.
// Latency: pad->rd_data SYNC_STAGES clocks; drive_req->drive_ack TURN_CYCLES+1 clocks; wr_en->pad one clock.
// Backpressure: none; drive_req is a level, drive_ack reports actual driving.
// Ports: clk, reset (async, active-high), pad[WIDTH] (pins), bus (iobuf_bank_ctl_if.slave host port).
// Option: define IOBUF_BANK_CHECK_EN to add the drive/readback contention checker (err_contention).
module iobuf_bank_ctl
    import iobuf_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire [WIDTH-1:0]   pad,
    iobuf_bank_ctl_if.slave   bus
);

    localparam int CW = cnt_width(TURN_CYCLES, SYNC_STAGES);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || TURN_CYCLES < TURN_MIN ||
        SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_param
        $error("iobuf_bank_ctl: parameter out of range");
    end

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             oe_n_nx;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    // A count of N-1 keeps the FSM in SETTLE/T2D for exactly N cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_SETTLE;
            cnt   <= CW'(SYNC_STAGES - 1);
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_SETTLE: begin
                // drive_req is deliberately not looked at until HIZ.
                if (cnt == '0) state_nx = ST_HIZ;
                else           cnt_nx   = cnt - CW'(1);
            end
            ST_HIZ: begin
                if (bus.drive_req) begin
                    state_nx = ST_T2D;
                    cnt_nx   = CW'(TURN_CYCLES - 1);
                end
            end
            ST_T2D: begin
                if (!bus.drive_req)  state_nx = ST_HIZ;
                else if (cnt == '0)  state_nx = ST_DRIVE;
                else                 cnt_nx   = cnt - CW'(1);
            end
            ST_DRIVE: begin
                // Wait for the far end to turn round and for our synchroniser to flush.
                if (!bus.drive_req) begin
                    state_nx = ST_SETTLE;
                    cnt_nx   = CW'(TURN_CYCLES + SYNC_STAGES - 1);
                end
            end
            default: state_nx = ST_SETTLE;
        endcase
    end

    // Enable flops are loaded from the next state so the pins track the state register exactly.
    assign oe_n_nx = (state_nx != ST_DRIVE);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        iobuf_pad_bit u_bit (
            .clk    (clk),
            .reset  (reset),
            .oe_n_d (oe_n_nx),
            .ld     (bus.wr_en),
            .d      (bus.wr_data[i]),
            .q      (out_q[i]),
            .pad    (pad[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pad;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign bus.rd_data   = sync_q[SYNC_STAGES-1];
    assign bus.rd_valid  = (state == ST_HIZ);
    assign bus.drive_ack = (state == ST_DRIVE);

`ifdef IOBUF_BANK_CHECK_EN
    logic [WIDTH-1:0] dly_q [SYNC_STAGES];
    logic [CW-1:0]    drv_cnt;
    logic             err_q;
    logic             cmp_en;
    logic             mismatch;

    // dly_q lines the output register up with rd_data; drv_cnt holds off the
    // comparison until the first driven value has crossed the synchroniser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) dly_q[i] <= '0;
            drv_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            dly_q[0] <= out_q;
            for (int i = 1; i < SYNC_STAGES; i++) dly_q[i] <= dly_q[i-1];
            if (state != ST_DRIVE)                 drv_cnt <= '0;
            else if (drv_cnt < CW'(SYNC_STAGES))   drv_cnt <= drv_cnt + CW'(1);
            // A fresh mismatch beats a simultaneous clear.
            if (mismatch)         err_q <= 1'b1;
            else if (bus.err_clr) err_q <= 1'b0;
        end
    end

    assign cmp_en             = (state == ST_DRIVE) && (drv_cnt >= CW'(SYNC_STAGES));
    assign mismatch           = cmp_en && (bus.rd_data != dly_q[SYNC_STAGES-1]);
    assign bus.err_contention = err_q;
`else
    wire unused_chk = ^{bus.err_clr, out_q};
    assign bus.err_contention = 1'b0;
`endif

endmodule

// File: doc/iobuf_bank_ctl.md
# iobuf_bank_ctl

Parametrised bank of bidirectional I/O pads with registered output data and a per-bank direction controller. A state machine enforces turnaround dead cycles whenever the bus changes direction, and the pad inputs pass through a multi-stage synchroniser. It sits between a PicoBlaze port/peripheral interface and an external shared bus, and replaces ad-hoc single-bit tri-state buffers.

## Interface
- WIDTH, 8: number of pad bits in the bank (1..32)
- TURN_CYCLES, 2: dead cycles with all bits high-Z before driving (>=1)
- SYNC_STAGES, 2: input synchroniser depth (2..4)

Ports:
- clk  in  1  bank clock; everything is rising-edge
- reset  in  1  asynchronous, active-high
- pad  inout  WIDTH  external pins
- drive_req  in  1  level; 1 requests that the bank drive the pads
- drive_ack  out  1  1 while the pads are actively driven
- wr_en  in  1  load wr_data into the output register
- wr_data  in  WIDTH  output data
- rd_data  out  WIDTH  synchronised pad value
- rd_valid  out  1  rd_data reflects settled, externally driven pads
- err_clr  in  1  clears err_contention
- err_contention  out  1  sticky drive-mismatch flag

## Operation
- Output register loads on wr_en in any state. Reset value is 0.
- Tri-state control is one registered bit per pad (1 = high-Z), computed from the next state.
- States:
  - SETTLE: high-Z. The counter runs SETTLE_LEN cycles, then the FSM moves to HIZ.
  - HIZ: high-Z, rd_valid=1. drive_req=1 moves the FSM to T2D.
  - T2D: high-Z for TURN_CYCLES cycles, then DRIVE. If drive_req drops during T2D, the FSM returns to HIZ on the next cycle.
  - DRIVE: pads driven from the output register, drive_ack=1. drive_req=0 moves the FSM to SETTLE with SETTLE_LEN = TURN_CYCLES+SYNC_STAGES.
- drive_req asserted during SETTLE is ignored until HIZ is reached. It then takes effect from HIZ.
- rd_data is the last synchroniser stage in every state. rd_valid = (state==HIZ).
- Reset values: state SETTLE with SETTLE_LEN = SYNC_STAGES, all bits high-Z, drive_ack=0, rd_valid=0, rd_data=0, synchroniser=0, err_contention=0.
- Reset asserted mid-DRIVE releases the pads asynchronously (high-Z) in the same instant.

## Timing
- drive_req rises in HIZ, sampled at edge 0:
  - T2D during cycles 1..TURN_CYCLES.
  - DRIVE, drive_ack=1 and pads driven from cycle TURN_CYCLES+1.
- wr_en at edge n while in DRIVE: new value on the pads after edge n+1 (one register).
- drive_req falls in DRIVE, sampled at edge 0:
  - Pads high-Z and drive_ack=0 from cycle 1.
  - rd_valid=1 from cycle TURN_CYCLES+SYNC_STAGES+1.
- Pad change to rd_data latency is SYNC_STAGES cycles.
- Release from reset: rd_valid=1 after SYNC_STAGES+1 cycles.

## Configuration
- IOBUF_BANK_CHECK_EN defined:
  - The output register is delayed SYNC_STAGES cycles to align with rd_data.
  - Comparison is enabled once the bank has been in DRIVE for at least SYNC_STAGES cycles.
  - Any bitwise mismatch sets err_contention at the next edge. It stays set until err_clr or reset.
  - When err_clr and a mismatch occur on the same edge, the set wins.
- Not defined: err_contention tied 0, err_clr ignored, no delay line or comparator.

## Structure
- Shared package iobuf_pkg holds:
  - The state encoding type (SETTLE, HIZ, T2D, DRIVE).
  - The counter width constant, $clog2(TURN_CYCLES+SYNC_STAGES+1).
  - Parameter range limits.
- Sub-module iobuf_pad_bit: one pad per instance with a registered tri-state flop and a registered output flop (IOB-packable) and the bufif0-style driver. It is instantiated WIDTH times by generate. The FSM, synchroniser and checker stay in the top level.

## Test plan
- Reset release, pads pulled 8'hA5 externally:
  - rd_valid=0 for SYNC_STAGES cycles, then 1 with rd_data=8'hA5.
  - Pads high-Z throughout.
- drive_req=1 with wr_data=8'h3C:
  - drive_ack rises exactly TURN_CYCLES+1 cycles after the request.
  - Pads read 8'h3C.
  - No bit driven during T2D.
- drive_req pulses high for 1 cycle with TURN_CYCLES=2:
  - FSM aborts from T2D back to HIZ.
  - drive_ack never rises and pads are never driven.
- Drop drive_req in DRIVE, then reassert it 1 cycle later:
  - Pads high-Z on the next cycle.
  - rd_valid returns after TURN_CYCLES+SYNC_STAGES cycles.
  - The re-request begins T2D only from HIZ.
- Assert reset mid-DRIVE: pads high-Z immediately (asynchronous), drive_ack=0, state SETTLE.
- With IOBUF_BANK_CHECK_EN, drive 8'hFF while the bench forces bit 0 low:
  - err_contention=1 SYNC_STAGES+1 cycles into DRIVE and holds.
  - err_clr with the conflict removed clears it.
  - Without the macro, err_contention stays 0.
